// File: rtl/reg_writeback_pkg.sv
// Shared widths, constants and the queue entry type for the register
// file write-back path.
package reg_writeback_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 5;
  localparam int NUM_REGS      = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Register 0 is hard-wired; writes to it are swallowed at the queue input.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_match.sv
// Youngest-match search over the write-back queue. Walks the entries from
// the oldest (rd_ptr) to the youngest so the last match found wins.
module reg_wb_match
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [ADDR_W-1:0]            chk_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Age-ordered scan; a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (chk_addr != ZERO_REG) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if (valid[idx] && (entries[idx].addr == chk_addr)) begin
          hit  = 1'b1;
          data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// In-order write-back queue in front of the register file. Accepts results
// over valid/ready, commits one entry per cycle when the file is ready and
// exposes a pending-write lookup for operand forwarding. Data and address
// widths come from reg_writeback_pkg; DEPTH must be a power of two >= 2.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rf_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        chk_addr,
  output logic                     chk_hit,
  output logic [DATA_W-1:0]        chk_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, never on the commit side this cycle.
  assign wb_ready = (count < FULL);

  // Register-0 handshakes complete but never occupy a slot.
  assign push = wb_valid && wb_ready && (wb_addr != ZERO_REG);

  assign rf_we    = (count != '0) && rf_ready;
  assign pop      = rf_we;
  assign rf_waddr = entries[rd_ptr].addr;
  assign rf_wdata = entries[rd_ptr].data;

  // Queue storage, pointers and occupancy. Push and pop never target the
  // same slot: a pop needs count>0 and a push at count==DEPTH is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= '{addr: wb_addr, data: wb_data};
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  reg_wb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries  (entries),
    .valid    (valid),
    .rd_ptr   (rd_ptr),
    .chk_addr (chk_addr),
    .hit      (chk_hit),
    .data     (chk_data)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a vector table for the single-cycle
// behaviour plus hand-written sequences for steady push/pop and reset.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic [15:0] chk_data;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rf_ready (rf_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .chk_data (chk_data),
    .count    (count)
  );

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [15:0] d;
    logic        rr;
    logic [4:0]  ca;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_hit;
    logic [15:0] e_cd;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } ent_t;

  vec_t vecs [21];
  ent_t model [$];

  function automatic vec_t mk(logic v, logic [4:0] a, logic [15:0] d, logic rr,
                              logic [4:0] ca, logic e_rdy, logic e_we,
                              logic [4:0] e_wa, logic [15:0] e_wd, logic e_hit,
                              logic [15:0] e_cd, logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.rr = rr; t.ca = ca;
    t.e_rdy = e_rdy; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd;
    t.e_hit = e_hit; t.e_cd = e_cd; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare just before the next rising edge,
  // then advance past the edge.
  task automatic run_vec(input int n, input vec_t t);
    wb_valid = t.v; wb_addr = t.a; wb_data = t.d;
    rf_ready = t.rr; chk_addr = t.ca;
    #4;
    check($sformatf("v%0d wb_ready", n), 32'(wb_ready), 32'(t.e_rdy));
    check($sformatf("v%0d rf_we", n),    32'(rf_we),    32'(t.e_we));
    if (t.e_we) begin
      check($sformatf("v%0d rf_waddr", n), 32'(rf_waddr), 32'(t.e_wa));
      check($sformatf("v%0d rf_wdata", n), 32'(rf_wdata), 32'(t.e_wd));
    end
    check($sformatf("v%0d chk_hit", n),  32'(chk_hit),  32'(t.e_hit));
    check($sformatf("v%0d chk_data", n), 32'(chk_data), 32'(t.e_cd));
    check($sformatf("v%0d count", n),    32'(count),    32'(t.e_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    //            v  a   d        rr ca  rdy we wa  wd       hit cd       cnt
    // single push, committed the following cycle
    vecs[0]  = mk(1, 3, 16'h00AA, 1, 3,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 3,  1, 1, 3, 16'h00AA, 1, 16'h00AA, 1);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 3,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    // fill to DEPTH with the file stalled, then drain in order
    vecs[3]  = mk(1, 1, 16'h0101, 0, 2,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[4]  = mk(1, 2, 16'h0202, 0, 2,  1, 0, 0, 16'h0000, 0, 16'h0000, 1);
    vecs[5]  = mk(1, 3, 16'h0303, 0, 2,  1, 0, 0, 16'h0000, 1, 16'h0202, 2);
    vecs[6]  = mk(1, 4, 16'h0404, 0, 2,  1, 0, 0, 16'h0000, 1, 16'h0202, 3);
    vecs[7]  = mk(1, 7, 16'h0707, 0, 2,  0, 0, 0, 16'h0000, 1, 16'h0202, 4);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 1,  0, 1, 1, 16'h0101, 1, 16'h0101, 4);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 7,  1, 1, 2, 16'h0202, 0, 16'h0000, 3);
    vecs[10] = mk(0, 0, 16'h0000, 1, 3,  1, 1, 3, 16'h0303, 1, 16'h0303, 2);
    vecs[11] = mk(0, 0, 16'h0000, 1, 4,  1, 1, 4, 16'h0404, 1, 16'h0404, 1);
    vecs[12] = mk(0, 0, 16'h0000, 0, 4,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    // two writes to the same register: youngest forwarded, oldest committed first
    vecs[13] = mk(1, 5, 16'h1111, 0, 5,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[14] = mk(1, 5, 16'h2222, 0, 5,  1, 0, 0, 16'h0000, 1, 16'h1111, 1);
    vecs[15] = mk(0, 0, 16'h0000, 0, 5,  1, 0, 0, 16'h0000, 1, 16'h2222, 2);
    vecs[16] = mk(0, 0, 16'h0000, 1, 5,  1, 1, 5, 16'h1111, 1, 16'h2222, 2);
    vecs[17] = mk(0, 0, 16'h0000, 1, 5,  1, 1, 5, 16'h2222, 1, 16'h2222, 1);
    vecs[18] = mk(0, 0, 16'h0000, 1, 5,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    // register 0 write is accepted but dropped
    vecs[19] = mk(1, 0, 16'hFFFF, 1, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[20] = mk(0, 0, 16'h0000, 1, 0,  1, 0, 0, 16'h0000, 0, 16'h0000, 0);

    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    rf_ready = 1'b1; chk_addr = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #4;
    check("rst count",    32'(count),    32'd0);
    check("rst wb_ready", 32'(wb_ready), 32'd1);
    check("rst rf_we",    32'(rf_we),    32'd0);
    check("rst chk_hit",  32'(chk_hit),  32'd0);
    check("rst rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst rf_wdata", 32'(rf_wdata), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

    // Steady state at occupancy 2 with push and pop every cycle; the
    // pointers wrap several times.
    model.delete();
    wb_valid = 1'b1; rf_ready = 1'b0; chk_addr = '0;
    wb_addr = 5'd10; wb_data = 16'h5A00; model.push_back('{5'd10, 16'h5A00});
    @(posedge clk); #1;
    wb_addr = 5'd11; wb_data = 16'h5A01; model.push_back('{5'd11, 16'h5A01});
    @(posedge clk); #1;
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1'b1;
      wb_addr  = 5'(12 + i);
      wb_data  = 16'h5A02 + 16'(i);
      #4;
      check($sformatf("pp%0d count", i),    32'(count),    32'(model.size()));
      check($sformatf("pp%0d rf_we", i),    32'(rf_we),    32'd1);
      check($sformatf("pp%0d wb_ready", i), 32'(wb_ready), 32'd1);
      check($sformatf("pp%0d rf_waddr", i), 32'(rf_waddr), 32'(model[0].a));
      check($sformatf("pp%0d rf_wdata", i), 32'(rf_wdata), 32'(model[0].d));
      @(posedge clk); #1;
      void'(model.pop_front());
      model.push_back('{5'(12 + i), 16'h5A02 + 16'(i)});
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      check($sformatf("drain%0d rf_we", i),    32'(rf_we),    32'd1);
      check($sformatf("drain%0d rf_waddr", i), 32'(rf_waddr), 32'(model[0].a));
      check($sformatf("drain%0d rf_wdata", i), 32'(rf_wdata), 32'(model[0].d));
      @(posedge clk); #1;
      void'(model.pop_front());
    end
    #4;
    check("drain count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Reset with three entries queued: all of them must be discarded.
    rf_ready = 1'b0; wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_addr = 5'(20 + i); wb_data = 16'hC000 + 16'(i);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    #4;
    check("prerst count", 32'(count), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rf_ready = 1'b1; chk_addr = 5'd20;
    #4;
    check("postrst count",    32'(count),    32'd0);
    check("postrst rf_we",    32'(rf_we),    32'd0);
    check("postrst chk_hit",  32'(chk_hit),  32'd0);
    check("postrst wb_ready", 32'(wb_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_addr = 5'(20 + (i % 3));
      #4;
      check($sformatf("postrst%0d rf_we", i),   32'(rf_we),   32'd0);
      check($sformatf("postrst%0d chk_hit", i), 32'(chk_hit), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
